booth_div_seq: RTL and testbench

Sequential signed two's-complement divider, the inverse of the team's combinational Booth multiplier. Accepts dividend and divisor on a start pulse. Runs one restoring-division step per clock over magnitudes, then applies sign correction. Returns quotient and remainder with a done pulse, for datapaths that must undo or check multiplier results.

---
 rtl/booth_div_seq.sv | 140 ++++++++++++++
 tb/tb_booth_div_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_div_seq.sv
// Sequential signed divider: one restoring step per clock on operand magnitudes,
// followed by a single sign-correction cycle. Divide-by-zero answers on the start edge.
module booth_div_seq #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int unsigned CW = $clog2(W + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e         state_q, state_d;
    logic [W:0]     a_q, a_d;
    logic [W-1:0]   q_q, q_d;
    logic [W-1:0]   d_q, d_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           sn_q, sn_d, sd_q, sd_d;
    logic           ovf_pend_q, ovf_pend_d;
    logic [W-1:0]   quot_q, quot_d, rem_q, rem_d;
    logic           dbz_q, dbz_d, ovf_q, ovf_d, done_q, done_d;

    logic [W-1:0]   dividend_mag, divisor_mag;
    logic [W:0]     a_sh, trial;

    // Magnitude of the most negative value is 2^(W-1), which still fits unsigned.
    assign dividend_mag = dividend[W-1] ? -dividend : dividend;
    assign divisor_mag  = divisor[W-1]  ? -divisor  : divisor;
    assign a_sh         = {a_q[W-1:0], q_q[W-1]};
    assign trial        = a_sh - {1'b0, d_q};

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        q_d        = q_q;
        d_d        = d_q;
        cnt_d      = cnt_q;
        sn_d       = sn_q;
        sd_d       = sd_q;
        ovf_pend_d = ovf_pend_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dbz_d      = dbz_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (divisor == '0) begin
                        quot_d = '1;
                        rem_d  = dividend;
                        dbz_d  = 1'b1;
                        ovf_d  = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        state_d    = StCalc;
                        a_d        = '0;
                        q_d        = dividend_mag;
                        d_d        = divisor_mag;
                        sn_d       = dividend[W-1];
                        sd_d       = divisor[W-1];
                        ovf_pend_d = (dividend == {1'b1, {(W-1){1'b0}}}) && (divisor == '1);
                        cnt_d      = '0;
                        dbz_d      = 1'b0;
                        ovf_d      = 1'b0;
                    end
                end
            end
            StCalc: begin
                // The cycle after the last step only hands over to sign correction.
                if (cnt_q == CW'(W)) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    q_d   = {q_q[W-2:0], ~trial[W]};
                    a_d   = trial[W] ? a_sh : trial;
                end
            end
            StFix: begin
                quot_d  = (sn_q ^ sd_q) ? -q_q : q_q;
                rem_d   = sn_q ? -a_q[W-1:0] : a_q[W-1:0];
                ovf_d   = ovf_pend_q;
                dbz_d   = 1'b0;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            a_q        <= '0;
            q_q        <= '0;
            d_q        <= '0;
            cnt_q      <= '0;
            sn_q       <= 1'b0;
            sd_q       <= 1'b0;
            ovf_pend_q <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            q_q        <= q_d;
            d_q        <= d_d;
            cnt_q      <= cnt_d;
            sn_q       <= sn_d;
            sd_q       <= sd_d;
            ovf_pend_q <= ovf_pend_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dbz_q      <= dbz_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_booth_div_seq.sv
// Bench for booth_div_seq: transaction-level model checked every cycle, plus directed
// literal expectations and an exhaustive W=4 operand sweep.
module tb_booth_div_seq;

    localparam int unsigned W = 4;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ovf;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend, divisor;
    logic         busy, done, div_by_zero, overflow;
    logic [W-1:0] quotient, remainder;

    int n_checks = 0;
    int n_pass   = 0;

    booth_div_seq #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Plain signed arithmetic: / and % truncate toward zero, remainder follows dividend.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t res;
        int   sa, sb, qi, ri;
        sa = $signed(a);
        sb = $signed(b);
        res = '0;
        if (sb == 0) begin
            res.q   = '1;
            res.r   = a;
            res.dbz = 1'b1;
        end else begin
            qi      = sa / sb;
            ri      = sa % sb;
            res.q   = qi[W-1:0];
            res.r   = ri[W-1:0];
            res.ovf = (sa == -(1 << (W - 1))) && (sb == -1);
        end
        return res;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    // Transaction model: counts down W+2 edges from acceptance to the result edge.
    res_t m_now, pend, exp_res;
    int   m_left;
    logic exp_busy, exp_done;

    assign m_now = model(dividend, divisor);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left   <= 0;
            exp_busy <= 1'b0;
            exp_done <= 1'b0;
            exp_res  <= '0;
            pend     <= '0;
        end else begin
            exp_done <= 1'b0;
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    exp_done <= 1'b1;
                    exp_busy <= 1'b0;
                    exp_res  <= pend;
                end
            end else if (start) begin
                if (m_now.dbz) begin
                    exp_done <= 1'b1;
                    exp_res  <= m_now;
                end else begin
                    m_left      <= W + 2;
                    pend        <= m_now;
                    exp_busy    <= 1'b1;
                    exp_res.dbz <= 1'b0;
                    exp_res.ovf <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("cmp_busy", 32'(busy), 32'(exp_busy));
            check("cmp_done", 32'(done), 32'(exp_done));
            check("cmp_quotient", 32'(quotient), 32'(exp_res.q));
            check("cmp_remainder", 32'(remainder), 32'(exp_res.r));
            check("cmp_div_by_zero", 32'(div_by_zero), 32'(exp_res.dbz));
            check("cmp_overflow", 32'(overflow), 32'(exp_res.ovf));
        end
    end

    // Caller sits on a negedge; returns on the negedge after the accepting edge.
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic check_res(input string name, input logic [W-1:0] q, input logic [W-1:0] r,
                             input logic dbz, input logic ovf);
        check({name, "_q"}, 32'(quotient), 32'(q));
        check({name, "_r"}, 32'(remainder), 32'(r));
        check({name, "_dbz"}, 32'(div_by_zero), 32'(dbz));
        check({name, "_ovf"}, 32'(overflow), 32'(ovf));
    endtask

    initial begin
        int   n;
        res_t mr;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        mr = model(4'd7, 4'd2);
        check("model_7_2", 32'(mr), 32'({4'b0011, 4'b0001, 1'b0, 1'b0}));
        mr = model(4'b1001, 4'd2);
        check("model_m7_2", 32'(mr), 32'({4'b1101, 4'b1111, 1'b0, 1'b0}));
        mr = model(4'b1000, 4'b1111);
        check("model_ovf", 32'(mr), 32'({4'b1000, 4'b0000, 1'b0, 1'b1}));
        mr = model(4'd5, 4'd0);
        check("model_dbz", 32'(mr), 32'({4'b1111, 4'b0101, 1'b1, 1'b0}));

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check_res("rst", 4'd0, 4'd0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        @(negedge clk);

        op(4'd7, 4'd2);
        wait_done(n);
        check("lat_7_2", 32'(n), 32'd6);
        check_res("d_7_2", 4'b0011, 4'b0001, 1'b0, 1'b0);

        op(4'b1001, 4'd2);
        wait_done(n);
        check_res("d_m7_2", 4'b1101, 4'b1111, 1'b0, 1'b0);
        op(4'd7, 4'b1110);
        wait_done(n);
        check_res("d_7_m2", 4'b1101, 4'b0001, 1'b0, 1'b0);
        op(4'b1010, 4'b1101);
        wait_done(n);
        check_res("d_m6_m3", 4'b0010, 4'b0000, 1'b0, 1'b0);

        op(4'b1000, 4'b1111);
        wait_done(n);
        check_res("d_m8_m1", 4'b1000, 4'b0000, 1'b0, 1'b1);
        op(4'b1000, 4'b0001);
        wait_done(n);
        check_res("d_m8_1", 4'b1000, 4'b0000, 1'b0, 1'b0);

        op(4'd5, 4'd0);
        check("lat_dbz", 32'(n), 32'd6);
        wait_done(n);
        check("lat_dbz_zero", 32'(n), 32'd0);
        check("dbz_busy", 32'(busy), 32'd0);
        check_res("d_5_0", 4'b1111, 4'b0101, 1'b1, 1'b0);
        op(4'd7, 4'd2);
        check("dbz_cleared", 32'(div_by_zero), 32'd0);
        wait_done(n);
        check_res("d_after_dbz", 4'b0011, 4'b0001, 1'b0, 1'b0);

        // Start while busy must not disturb the running 7/2.
        op(4'd7, 4'd2);
        @(negedge clk);
        op(4'd1, 4'd1);
        wait_done(n);
        check("lat_ignored", 32'(n + 2), 32'd6);
        check_res("d_ignored", 4'b0011, 4'b0001, 1'b0, 1'b0);

        op(4'd6, 4'd4);
        wait_done(n);
        check("lat_b2b", 32'(n), 32'd6);
        check_res("d_6_4", 4'b0001, 4'b0010, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a division.
        op(4'd7, 4'd2);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check_res("arst", 4'd0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        repeat (8) @(negedge clk);
        check("arst_no_done", 32'(done), 32'd0);
        op(4'd6, 4'd3);
        wait_done(n);
        check_res("d_6_3", 4'b0010, 4'b0000, 1'b0, 1'b0);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                op(4'(a), 4'(b));
                wait_done(n);
                check("sweep_lat", 32'(n), (b == 0) ? 32'd0 : 32'd6);
                mr = model(4'(a), 4'(b));
                check_res("sweep", mr.q, mr.r, mr.dbz, mr.ovf);
            end
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
